// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator request-port driver.
package calc_pkg;

   localparam int unsigned CALC_DATA_W = 32;
   localparam int unsigned CALC_CMD_W  = 4;
   localparam int unsigned CALC_RESP_W = 2;

   typedef enum logic [CALC_CMD_W-1:0] {
      NOP = 4'd0,
      ADD = 4'd1,
      SUB = 4'd2,
      SHL = 4'd5,
      SHR = 4'd6
   } calc_cmd_e;

   typedef enum logic [CALC_RESP_W-1:0] {
      NONE    = 2'd0,
      OK      = 2'd1,
      OVF_UNF = 2'd2,
      INVALID = 2'd3
   } calc_resp_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP2  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } drv_state_e;

endpackage

// File: rtl/calc_timeout_ctr.sv
// Wait-cycle counter: cleared before each wait, advanced per empty sample,
// last_c flags the sample that exhausts the budget.
module calc_timeout_ctr
   import calc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10
) (
   input  logic c_clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic last_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Count empty samples; the FSM leaves WAIT on the last one, so no wrap.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CNT_W'(1);
   end

   assign last_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc_req_driver.sv
// Feeds one calculator request port: two-cycle issue, wait for a response
// or timeout, then hand the result back on a valid/ready handshake.
module calc_req_driver
   import calc_pkg::*;
#(
   parameter int unsigned DATA_W         = CALC_DATA_W,
   parameter int unsigned CMD_W          = CALC_CMD_W,
   parameter int unsigned TIMEOUT_CYCLES = 10
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic              txn_valid,
   output logic              txn_ready,
   input  logic [CMD_W-1:0]  txn_cmd,
   input  logic [DATA_W-1:0] txn_op1,
   input  logic [DATA_W-1:0] txn_op2,
   output logic [CMD_W-1:0]  req_cmd_out,
   output logic [DATA_W-1:0] req_data_out,
   input  logic [1:0]        calc_resp_in,
   input  logic [DATA_W-1:0] calc_data_in,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_resp,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              spurious_resp
);

   drv_state_e        state, state_nxt;
   logic [CMD_W-1:0]  cmd_q, cmd_nxt;
   logic [DATA_W-1:0] op2_q, op2_nxt;

   logic              txn_ready_nxt;
   logic [CMD_W-1:0]  req_cmd_nxt;
   logic [DATA_W-1:0] req_data_nxt;
   logic              rsp_valid_nxt;
   logic [1:0]        rsp_resp_nxt;
   logic [DATA_W-1:0] rsp_data_nxt;
   logic              rsp_timeout_nxt;
   logic              busy_nxt;
   logic              spurious_nxt;

   logic              ctr_clr, ctr_en, ctr_last_c;
   logic              resp_seen_c;

   assign resp_seen_c = (calc_resp_in != 2'(NONE));

   calc_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .c_clk  (c_clk),
      .reset  (reset),
      .clr    (ctr_clr),
      .en     (ctr_en),
      .last_c (ctr_last_c)
   );

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cmd_q         <= '0;
         op2_q         <= '0;
         txn_ready     <= 1'b1;
         req_cmd_out   <= '0;
         req_data_out  <= '0;
         rsp_valid     <= 1'b0;
         rsp_resp      <= '0;
         rsp_data      <= '0;
         rsp_timeout   <= 1'b0;
         busy          <= 1'b0;
         spurious_resp <= 1'b0;
      end else begin
         state         <= state_nxt;
         cmd_q         <= cmd_nxt;
         op2_q         <= op2_nxt;
         txn_ready     <= txn_ready_nxt;
         req_cmd_out   <= req_cmd_nxt;
         req_data_out  <= req_data_nxt;
         rsp_valid     <= rsp_valid_nxt;
         rsp_resp      <= rsp_resp_nxt;
         rsp_data      <= rsp_data_nxt;
         rsp_timeout   <= rsp_timeout_nxt;
         busy          <= busy_nxt;
         spurious_resp <= spurious_nxt;
      end
   end

   // Next state and next output values; the request bus idles at zero.
   always_comb begin
      state_nxt       = state;
      cmd_nxt         = cmd_q;
      op2_nxt         = op2_q;
      txn_ready_nxt   = txn_ready;
      req_cmd_nxt     = '0;
      req_data_nxt    = '0;
      rsp_valid_nxt   = rsp_valid;
      rsp_resp_nxt    = rsp_resp;
      rsp_data_nxt    = rsp_data;
      rsp_timeout_nxt = rsp_timeout;
      spurious_nxt    = spurious_resp | (resp_seen_c && (state != WAIT));
      ctr_clr         = 1'b0;
      ctr_en          = 1'b0;

      case (state)
         IDLE: begin
            if (txn_valid && txn_ready) begin
               req_cmd_nxt   = txn_cmd;
               req_data_nxt  = txn_op1;
               cmd_nxt       = txn_cmd;
               op2_nxt       = txn_op2;
               txn_ready_nxt = 1'b0;
               state_nxt     = OP2;
            end
         end
         OP2: begin
            req_data_nxt = op2_q;
            ctr_clr      = 1'b1;
            if (cmd_q == CMD_W'(NOP)) begin
               rsp_valid_nxt   = 1'b1;
               rsp_resp_nxt    = 2'(NONE);
               rsp_data_nxt    = '0;
               rsp_timeout_nxt = 1'b0;
               state_nxt       = RESP;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (resp_seen_c) begin
               rsp_valid_nxt   = 1'b1;
               rsp_resp_nxt    = calc_resp_in;
               rsp_data_nxt    = calc_data_in;
               rsp_timeout_nxt = 1'b0;
               state_nxt       = RESP;
            end else begin
               ctr_en = 1'b1;
               if (ctr_last_c) begin
                  rsp_valid_nxt   = 1'b1;
                  rsp_resp_nxt    = 2'(NONE);
                  rsp_data_nxt    = '0;
                  rsp_timeout_nxt = 1'b1;
                  state_nxt       = RESP;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               txn_ready_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_calc_req_driver.sv
// Randomised scoreboard bench for calc_req_driver with a behavioural calculator.
module tb_calc_req_driver;

   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 4;
   localparam int unsigned TMO = 10;

   logic          c_clk;
   logic          reset;
   logic          txn_valid;
   logic          txn_ready;
   logic [CW-1:0] txn_cmd;
   logic [DW-1:0] txn_op1, txn_op2;
   logic [CW-1:0] req_cmd_out;
   logic [DW-1:0] req_data_out;
   logic [1:0]    calc_resp_in;
   logic [DW-1:0] calc_data_in;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_resp;
   logic [DW-1:0] rsp_data;
   logic          rsp_timeout;
   logic          busy;
   logic          spurious_resp;

   typedef struct packed {
      logic [1:0]    resp;
      logic [DW-1:0] data;
      logic          to;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

   calc_req_driver #(
      .DATA_W         (DW),
      .CMD_W          (CW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .c_clk         (c_clk),
      .reset         (reset),
      .txn_valid     (txn_valid),
      .txn_ready     (txn_ready),
      .txn_cmd       (txn_cmd),
      .txn_op1       (txn_op1),
      .txn_op2       (txn_op2),
      .req_cmd_out   (req_cmd_out),
      .req_data_out  (req_data_out),
      .calc_resp_in  (calc_resp_in),
      .calc_data_in  (calc_data_in),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_resp      (rsp_resp),
      .rsp_data      (rsp_data),
      .rsp_timeout   (rsp_timeout),
      .busy          (busy),
      .spurious_resp (spurious_resp)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Calculator behaviour: what a correct calc1 port would answer.
   function automatic void calc_model(input logic [CW-1:0] cmd, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b, output logic [1:0] r,
                                      output logic [DW-1:0] d);
      logic [DW:0] s;
      case (cmd)
         4'd1: begin s = {1'b0, a} + {1'b0, b}; d = s[DW-1:0]; r = s[DW] ? 2'd2 : 2'd1; end
         4'd2: begin d = a - b; r = (b > a) ? 2'd2 : 2'd1; end
         4'd5: begin d = a << b[4:0]; r = 2'd1; end
         4'd6: begin d = a >> b[4:0]; r = 2'd1; end
         default: begin d = '0; r = 2'd3; end
      endcase
   endfunction

   // Result consumer readiness, changed just after each rising edge.
   always @(posedge c_clk) begin
      #1;
      case (rdy_mode)
         0:       rsp_ready = 1'b1;
         1:       rsp_ready = 1'($urandom % 2);
         default: rsp_ready = 1'b0;
      endcase
   end

   // Monitor: every completed result handshake is checked against the queue.
   always @(negedge c_clk) begin : monitor
      exp_t e;
      if (reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
         end
      end
   end

   // One full transaction; k = WAIT sample that carries the answer (k >= TMO: silent).
   task automatic do_txn(input logic [CW-1:0] cmd, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int k, input bit bp);
      logic [1:0]    mr;
      logic [DW-1:0] md;
      exp_t          e;
      int            lim;
      int            n;
      bit            silent;
      int            saved_mode;
      calc_model(cmd, a, b, mr, md);
      silent = (k >= int'(TMO));
      lim    = silent ? int'(TMO) - 1 : k;
      if (cmd == '0)    begin e.resp = 2'd0; e.data = '0; e.to = 1'b0; end
      else if (silent)  begin e.resp = 2'd0; e.data = '0; e.to = 1'b1; end
      else              begin e.resp = mr;   e.data = md; e.to = 1'b0; end

      chk("idle_txn_ready", 32'(txn_ready), 32'd1);
      txn_valid = 1'b1; txn_cmd = cmd; txn_op1 = a; txn_op2 = b;
      exp_q.push_back(e);
      @(posedge c_clk);
      @(negedge c_clk);
      txn_valid = 1'($urandom % 2);
      txn_cmd = CW'($urandom); txn_op1 = $urandom; txn_op2 = $urandom;
      chk("bus_cmd_first", 32'(req_cmd_out), 32'(cmd));
      chk("bus_op1", req_data_out, a);
      chk("txn_ready_busy", 32'(txn_ready), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      calc_resp_in = 2'd0;
      @(negedge c_clk);
      chk("bus_cmd_second", 32'(req_cmd_out), 32'd0);
      chk("bus_op2", req_data_out, b);
      if (cmd == '0) begin
         chk("nop_rsp_valid", 32'(rsp_valid), 32'd1);
      end else begin
         for (int i = 0; i <= lim; i++) begin
            if (!silent && i == k) begin calc_resp_in = mr; calc_data_in = md; end
            else begin calc_resp_in = 2'd0; calc_data_in = $urandom; end
            @(negedge c_clk);
            if (i == 0) begin
               chk("bus_cmd_wait", 32'(req_cmd_out), 32'd0);
               chk("bus_data_wait", req_data_out, 32'd0);
            end
            chk("rsp_valid_latency", 32'(rsp_valid), 32'(i == lim));
         end
         calc_resp_in = 2'd0;
      end

      if (bp) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge c_clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_resp", 32'(rsp_resp), 32'(e.resp));
            chk("bp_data", rsp_data, e.data);
            chk("bp_timeout", 32'(rsp_timeout), 32'(e.to));
            chk("bp_txn_ready", 32'(txn_ready), 32'd0);
            if (i == 0) chk("spurious_before", 32'(spurious_resp), 32'd0);
            if (i >= 2) chk("spurious_set", 32'(spurious_resp), 32'd1);
            if (i == 1) begin calc_resp_in = 2'd1; calc_data_in = 32'hDEAD_BEEF; end
            else        calc_resp_in = 2'd0;
         end
         calc_resp_in = 2'd0;
         saved_mode = rdy_mode;
         rdy_mode = 0;
      end

      n = 0;
      while (rsp_valid && n < 100) begin
         @(negedge c_clk);
         n++;
      end
      txn_valid = 1'b0;
      chk("rsp_drain", 32'(rsp_valid), 32'd0);
      chk("txn_ready_after", 32'(txn_ready), 32'd1);
      chk("bus_idle_cmd", 32'(req_cmd_out), 32'd0);
      chk("bus_idle_data", req_data_out, 32'd0);
      if (bp) rdy_mode = saved_mode;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin : stim
      logic [CW-1:0] cmds[8];
      logic [CW-1:0] c;
      logic [DW-1:0] a, b;
      cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd2; cmds[3] = 4'd5;
      cmds[4] = 4'd6; cmds[5] = 4'd3; cmds[6] = 4'd7; cmds[7] = 4'd15;

      reset = 1'b0; txn_valid = 1'b0; txn_cmd = '0; txn_op1 = '0; txn_op2 = '0;
      calc_resp_in = 2'd0; calc_data_in = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge c_clk);
      chk("rst_txn_ready", 32'(txn_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_cmd", 32'(req_cmd_out), 32'd0);
      chk("rst_req_data", req_data_out, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_spurious", 32'(spurious_resp), 32'd0);
      reset = 1'b1;
      @(negedge c_clk);

      // Directed cases.
      do_txn(4'd1, 32'h5, 32'h1, 2, 1'b0);
      do_txn(4'd1, 32'hFFFF_FFFF, 32'h1, 1, 1'b0);
      do_txn(4'd1, 32'h1234, 32'h1, int'(TMO), 1'b0);
      do_txn(4'd0, 32'h64, 32'h27, 0, 1'b0);
      do_txn(4'd3, 32'h1, 32'h2, 0, 1'b0);
      do_txn(4'd1, 32'h0, 32'h0, int'(TMO) - 1, 1'b0);
      rdy_mode = 2;
      @(negedge c_clk);
      @(negedge c_clk);
      do_txn(4'd2, 32'h3, 32'h7, 0, 1'b1);
      chk("spurious_sticky", 32'(spurious_resp), 32'd1);

      // Random traffic with random consumer stalls.
      rdy_mode = 1;
      for (int t = 0; t < 40; t++) begin
         c = cmds[$urandom_range(0, 7)];
         a = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
         b = ($urandom % 4 == 0) ? 32'h0 : $urandom;
         do_txn(c, a, b, $urandom_range(0, 12), 1'b0);
      end
      rdy_mode = 0;
      @(negedge c_clk);
      @(negedge c_clk);
      chk("spurious_still_set", 32'(spurious_resp), 32'd1);

      // Reset two cycles into WAIT drops the transaction.
      txn_valid = 1'b1; txn_cmd = 4'd1; txn_op1 = 32'h9; txn_op2 = 32'h9;
      @(posedge c_clk);
      @(negedge c_clk);
      txn_valid = 1'b0;
      repeat (3) @(negedge c_clk);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_req_cmd", 32'(req_cmd_out), 32'd0);
      chk("arst_req_data", req_data_out, 32'd0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_rsp_resp", 32'(rsp_resp), 32'd0);
      chk("arst_rsp_data", rsp_data, 32'd0);
      chk("arst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_spurious", 32'(spurious_resp), 32'd0);
      chk("arst_txn_ready", 32'(txn_ready), 32'd1);
      repeat (2) @(negedge c_clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge c_clk);
         chk("post_rst_no_valid", 32'(rsp_valid), 32'd0);
      end
      chk("post_rst_txn_ready", 32'(txn_ready), 32'd1);
      do_txn(4'd1, 32'h7, 32'h8, 1, 1'b0);

      repeat (3) @(negedge c_clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
